// File: rtl/keypad_defs.sv
// keypad_defs: shared state encoding, frame classes and key legend for the keypad scanner
// No ports; imported by keypad_row_scan and keypad_scanner.
package keypad_defs;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    typedef enum logic [1:0] {EMPTY, SINGLE, MULTI} frame_class_t;

    localparam logic [3:0] ROW_RESET = 4'b1110;

    // Entry i is the printed legend of key index row*4+col (entry 0 in the low nibble)
    localparam logic [15:0][3:0] LEGEND = 64'hDEF0_C987_B654_A321;

endpackage

// File: rtl/keypad_row_scan.sv
// keypad_row_scan: drives one-hot row strobes, synchronizes column returns and assembles 16-bit frames
// Ports:
//   clk100MHz  in   system clock
//   rst        in   asynchronous active-high reset
//   COL[3:0]   in   column returns, active-low, asynchronous
//   ROW[3:0]   out  row strobes, active-low one-hot
//   frame_done out  one-cycle pulse once row 3 has been sampled
//   frame      out  snapshot of all 16 keys (bit row*4+col, active-high), valid with frame_done
module keypad_row_scan
    import keypad_defs::*;
#(
    parameter int SCAN_DIV = 25000
) (
    input  logic        clk100MHz,
    input  logic        rst,
    input  logic [3:0]  COL,
    output logic [3:0]  ROW,
    output logic        frame_done,
    output logic [15:0] frame
);

    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0] dwell;
    logic [1:0]    row_idx;
    logic [3:0]    col_meta;
    logic [3:0]    col_sync;
    logic          dwell_end;

    assign dwell_end = dwell == DW'(SCAN_DIV - 1);

    // Sampling at the end of the dwell leaves the synchronizer time to settle after each row change
    always_ff @(posedge clk100MHz or posedge rst) begin
        if (rst) begin
            dwell      <= '0;
            row_idx    <= '0;
            ROW        <= ROW_RESET;
            col_meta   <= 4'hF;
            col_sync   <= 4'hF;
            frame      <= '0;
            frame_done <= 1'b0;
        end else begin
            col_meta   <= COL;
            col_sync   <= col_meta;
            frame_done <= dwell_end && row_idx == 2'd3;
            if (dwell_end) begin
                dwell                        <= '0;
                row_idx                      <= row_idx + 2'd1;
                ROW                          <= {ROW[2:0], ROW[3]};
                frame[{row_idx, 2'b00} +: 4] <= ~col_sync;
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad, debounces whole frames and reports one hex key per press
// Ports:
//   clk100MHz     in   system clock
//   rst           in   asynchronous active-high reset
//   COL[3:0]      in   column returns, active-low, asynchronous
//   ROW[3:0]      out  row strobes, active-low one-hot
//   key_code[3:0] out  legend of the last accepted key, held until the next accept
//   key_valid     out  one-cycle pulse on accept
//   key_held      out  high from accept until the release is accepted
module keypad_scanner
    import keypad_defs::*;
#(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk100MHz,
    input  logic       rst,
    input  logic [3:0] COL,
    output logic [3:0] ROW,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int            CW   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] DONE = CW'(DEBOUNCE_SCANS);
    localparam bit            FAST = DEBOUNCE_SCANS == 1;

    logic          frame_done;
    logic [15:0]   frame;
    logic [3:0]    idx;
    frame_class_t  cls;
    state_t        state;
    logic [3:0]    cand;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    keypad_row_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk100MHz (clk100MHz),
        .rst       (rst),
        .COL       (COL),
        .ROW       (ROW),
        .frame_done(frame_done),
        .frame     (frame)
    );

    // idx is only meaningful for SINGLE frames, where it is the position of the lone set bit
    always_comb begin
        idx = '0;
        for (int i = 0; i < 16; i++)
            if (frame[i]) idx = 4'(i);
        cls = frame == 16'd0 ? EMPTY : $countones(frame) == 1 ? SINGLE : MULTI;
    end

    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge clk100MHz or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_done) begin
                case (state)
                    IDLE: if (cls == SINGLE) begin
                        cand <= idx;
                        if (FAST) begin
                            state     <= PRESSED;
                            key_code  <= LEGEND[idx];
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            state <= DEBOUNCE;
                            cnt   <= CW'(1);
                        end
                    end
                    DEBOUNCE: if (cls != SINGLE) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (idx != cand) begin
                        cand <= idx;
                        cnt  <= CW'(1);
                    end else if (cnt_inc == DONE) begin
                        state     <= PRESSED;
                        key_code  <= LEGEND[cand];
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                    // Rollover keys while held are ignored; only an all-empty frame starts a release
                    PRESSED: if (cls == EMPTY) begin
                        if (FAST) begin
                            state    <= IDLE;
                            key_held <= 1'b0;
                            cnt      <= '0;
                        end else begin
                            state <= RELEASE;
                            cnt   <= CW'(1);
                        end
                    end
                    RELEASE: if (cls != EMPTY) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt_inc == DONE) begin
                        state    <= IDLE;
                        key_held <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized and directed frame-level checks of keypad_scanner against a history-window model
module tb_keypad_scanner;

    localparam int DS    = 2;
    localparam int FRAME = 16;
    localparam logic [3:0] LEG [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                        4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

    logic        clk100MHz = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  COL;
    logic [3:0]  ROW;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = '0;

    int          total = 0;
    int          bad = 0;
    int          pulse_cnt = 0;
    logic [3:0]  pulse_code = '0;

    logic [15:0] hist[$];
    bit          m_held;
    logic [3:0]  m_code;
    int          m_pend;

    int          obs_pulse, exp_pulse;
    logic        obs_held, exp_held;
    logic [3:0]  obs_code, exp_code;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(DS)) dut (
        .clk100MHz(clk100MHz),
        .rst      (rst),
        .COL      (COL),
        .ROW      (ROW),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk100MHz = ~clk100MHz;

    // Passive keypad: a pressed key pulls its column low while its row strobe is low
    always_comb begin
        COL = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!ROW[r]) COL = COL & ~keys[r*4 +: 4];
    end

    always @(posedge clk100MHz)
        if (key_valid === 1'b1) begin
            pulse_cnt++;
            pulse_code = key_code;
        end

    // A press is accepted once the last DS frames since the previous accept/release are the same lone key;
    // a release once the last DS frames while held are all empty.
    task automatic step_model(input logic [15:0] k);
        bit same = 1'b1;
        hist.push_back(k);
        m_pend = 0;
        if (hist.size() >= DS) begin
            for (int i = 1; i < DS; i++)
                if (hist[hist.size() - 1 - i] != k) same = 1'b0;
            if (!m_held && same && $countones(k) == 1) begin
                m_held = 1'b1;
                m_code = LEG[$clog2(k)];
                m_pend = 1;
                hist.delete();
            end else if (m_held && same && k == 16'd0) begin
                m_held = 1'b0;
                hist.delete();
            end
        end
    endtask

    task automatic clear_model();
        hist.delete();
        m_held = 1'b0;
        m_code = '0;
        m_pend = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk100MHz);
        rst = 1'b1;
        repeat (2) @(negedge clk100MHz);
        rst = 1'b0;
        clear_model();
    endtask

    // Presents one whole frame; effects of the previous frame are what is visible by its end
    task automatic do_frame(input logic [15:0] k);
        int p0 = pulse_cnt;
        keys = k;
        exp_pulse = m_pend;
        exp_held  = m_held;
        exp_code  = m_code;
        repeat (FRAME) @(negedge clk100MHz);
        obs_pulse = pulse_cnt - p0;
        obs_held  = key_held;
        obs_code  = key_code;
        step_model(k);
    endtask

    task automatic test_reset();
        logic [3:0] exp_row;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            do_frame(16'h0020);
            total++;
            if (obs_pulse !== exp_pulse || obs_held !== exp_held || obs_code !== exp_code) begin
                bad++;
                $display("FAIL reset_pre f%0d: pulses=%0d held=%b code=%h, want pulses=%0d held=%b code=%h",
                         i, obs_pulse, obs_held, obs_code, exp_pulse, exp_held, exp_code);
            end
        end
        repeat ($urandom_range(1, 9)) @(posedge clk100MHz);
        #2 rst = 1'b1;
        #1;
        total++;
        if (ROW !== 4'b1110) begin bad++; $display("FAIL reset_row: got %b want 1110", ROW); end
        total++;
        if (key_code !== 4'h0) begin bad++; $display("FAIL reset_code: got %h want 0", key_code); end
        total++;
        if (key_held !== 1'b0) begin bad++; $display("FAIL reset_held: got %b want 0", key_held); end
        total++;
        if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        keys = '0;
        @(negedge clk100MHz);
        rst = 1'b0;
        clear_model();
        for (int i = 0; i < 32; i++) begin
            exp_row = ~(4'b0001 << ((i / 4) % 4));
            total++;
            if (ROW !== exp_row) begin
                bad++;
                $display("FAIL row_walk c%0d: got %b want %b", i, ROW, exp_row);
            end
            @(negedge clk100MHz);
        end
    endtask

    task automatic test_single();
        logic [15:0] seq[$] = {16'h0020, 16'h0020, 16'h0020, 16'h0020, 16'h0, 16'h0, 16'h0, 16'h0};
        int p0;
        apply_reset();
        p0 = pulse_cnt;
        foreach (seq[i]) begin
            do_frame(seq[i]);
            total++;
            if (obs_pulse !== exp_pulse || obs_held !== exp_held || obs_code !== exp_code) begin
                bad++;
                $display("FAIL single f%0d: pulses=%0d held=%b code=%h, want pulses=%0d held=%b code=%h",
                         i, obs_pulse, obs_held, obs_code, exp_pulse, exp_held, exp_code);
            end
        end
        total++;
        if (pulse_cnt - p0 !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", pulse_cnt - p0); end
        total++;
        if (pulse_code !== 4'h5) begin bad++; $display("FAIL single_code: got %h want 5", pulse_code); end
        total++;
        if (key_held !== 1'b0) begin bad++; $display("FAIL single_release: got %b want 0", key_held); end
    endtask

    task automatic test_bounce();
        logic [15:0] seq[$];
        int p0;
        for (int i = 0; i < 5; i++) begin seq.push_back(16'h0400); seq.push_back(16'h0); end
        for (int i = 0; i < 3; i++) seq.push_back(16'h0400);
        for (int i = 0; i < 3; i++) seq.push_back(16'h0);
        apply_reset();
        p0 = pulse_cnt;
        foreach (seq[i]) begin
            do_frame(seq[i]);
            total++;
            if (obs_pulse !== exp_pulse || obs_held !== exp_held || obs_code !== exp_code) begin
                bad++;
                $display("FAIL bounce f%0d: pulses=%0d held=%b code=%h, want pulses=%0d held=%b code=%h",
                         i, obs_pulse, obs_held, obs_code, exp_pulse, exp_held, exp_code);
            end
        end
        total++;
        if (pulse_cnt - p0 !== 1) begin bad++; $display("FAIL bounce_count: got %0d want 1", pulse_cnt - p0); end
        total++;
        if (pulse_code !== 4'h9) begin bad++; $display("FAIL bounce_code: got %h want 9", pulse_code); end
    endtask

    task automatic test_multi();
        logic [15:0] seq[$] = {16'h0003, 16'h0003, 16'h0003, 16'h0, 16'h8000, 16'h8000, 16'h8000,
                               16'h9000, 16'h9000, 16'h9000, 16'h0, 16'h0, 16'h0};
        int p0;
        apply_reset();
        p0 = pulse_cnt;
        foreach (seq[i]) begin
            do_frame(seq[i]);
            total++;
            if (obs_pulse !== exp_pulse || obs_held !== exp_held || obs_code !== exp_code) begin
                bad++;
                $display("FAIL multi f%0d: pulses=%0d held=%b code=%h, want pulses=%0d held=%b code=%h",
                         i, obs_pulse, obs_held, obs_code, exp_pulse, exp_held, exp_code);
            end
        end
        total++;
        if (pulse_cnt - p0 !== 1) begin bad++; $display("FAIL multi_count: got %0d want 1", pulse_cnt - p0); end
        total++;
        if (pulse_code !== 4'hD) begin bad++; $display("FAIL multi_code: got %h want d", pulse_code); end
    endtask

    task automatic test_glitch();
        logic [15:0] seq[$] = {16'h0008, 16'h0008, 16'h0008, 16'h0, 16'h0008, 16'h0008, 16'h0, 16'h0,
                               16'h0, 16'h0008, 16'h0008, 16'h0008, 16'h0, 16'h0, 16'h0};
        int p0;
        apply_reset();
        p0 = pulse_cnt;
        foreach (seq[i]) begin
            do_frame(seq[i]);
            total++;
            if (obs_pulse !== exp_pulse || obs_held !== exp_held || obs_code !== exp_code) begin
                bad++;
                $display("FAIL glitch f%0d: pulses=%0d held=%b code=%h, want pulses=%0d held=%b code=%h",
                         i, obs_pulse, obs_held, obs_code, exp_pulse, exp_held, exp_code);
            end
        end
        total++;
        if (pulse_cnt - p0 !== 2) begin bad++; $display("FAIL glitch_count: got %0d want 2", pulse_cnt - p0); end
        total++;
        if (pulse_code !== 4'hA) begin bad++; $display("FAIL glitch_code: got %h want a", pulse_code); end
    endtask

    task automatic test_reset_while_held();
        int p0;
        apply_reset();
        p0 = pulse_cnt;
        do_frame(16'h4000);
        total++;
        if (obs_pulse !== exp_pulse || obs_held !== exp_held || obs_code !== exp_code) begin
            bad++;
            $display("FAIL rwh_pre: pulses=%0d held=%b code=%h, want pulses=%0d held=%b code=%h",
                     obs_pulse, obs_held, obs_code, exp_pulse, exp_held, exp_code);
        end
        repeat ($urandom_range(2, 12)) @(negedge clk100MHz);
        @(posedge clk100MHz);
        #3 rst = 1'b1;
        @(negedge clk100MHz);
        @(negedge clk100MHz);
        rst = 1'b0;
        clear_model();
        total++;
        if (pulse_cnt - p0 !== 0) begin bad++; $display("FAIL rwh_nopulse: got %0d want 0", pulse_cnt - p0); end
        for (int i = 0; i < 3; i++) begin
            do_frame(16'h4000);
            total++;
            if (obs_pulse !== exp_pulse || obs_held !== exp_held || obs_code !== exp_code) begin
                bad++;
                $display("FAIL rwh f%0d: pulses=%0d held=%b code=%h, want pulses=%0d held=%b code=%h",
                         i, obs_pulse, obs_held, obs_code, exp_pulse, exp_held, exp_code);
            end
        end
        total++;
        if (pulse_cnt - p0 !== 1) begin bad++; $display("FAIL rwh_count: got %0d want 1", pulse_cnt - p0); end
        total++;
        if (pulse_code !== 4'hE) begin bad++; $display("FAIL rwh_code: got %h want e", pulse_code); end
        total++;
        if (key_held !== 1'b1) begin bad++; $display("FAIL rwh_held: got %b want 1", key_held); end
    endtask

    task automatic test_random();
        logic [3:0]  pool[3];
        logic [15:0] k;
        int          n = 0;
        int          sel;
        foreach (pool[j]) pool[j] = 4'($urandom_range(0, 15));
        apply_reset();
        for (int r = 0; r < 40; r++) begin
            sel = $urandom_range(0, 9);
            k = sel < 4 ? 16'h0 :
                sel < 8 ? 16'h1 << pool[$urandom_range(0, 2)] :
                          (16'h1 << pool[0]) | (16'h1 << pool[1]);
            repeat ($urandom_range(1, 3)) begin
                do_frame(k);
                total++;
                if (obs_pulse !== exp_pulse || obs_held !== exp_held || obs_code !== exp_code) begin
                    bad++;
                    $display("FAIL random f%0d keys=%h: pulses=%0d held=%b code=%h, want pulses=%0d held=%b code=%h",
                             n, k, obs_pulse, obs_held, obs_code, exp_pulse, exp_held, exp_code);
                end
                n++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            do_frame(16'h0);
            total++;
            if (obs_pulse !== exp_pulse || obs_held !== exp_held || obs_code !== exp_code) begin
                bad++;
                $display("FAIL random_tail f%0d: pulses=%0d held=%b code=%h, want pulses=%0d held=%b code=%h",
                         i, obs_pulse, obs_held, obs_code, exp_pulse, exp_held, exp_code);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_bounce();
        test_multi();
        test_glitch();
        test_reset_while_held();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
